// File: rtl/clip_record_controller.sv
// clip_record_controller
//   Record/playback sequencer for NUM_CLIPS audio clips that share one sample
//   RAM. Each clip owns a CLIP_DEPTH-sample window starting at
//   clip*CLIP_DEPTH. Samples are paced by sample_tick. The block tracks the
//   recorded length of every clip, and it supports stop, looped playback and
//   a one-cycle done pulse at the natural end of an operation.
//
// Ports
//   clock, reset_n        : system clock (rising edge), async active-low reset
//   record, play, stop    : level requests from the switch decoder
//   loop_en               : playback wraps to sample 0 at end of clip
//   clip_sel              : clip slot, sampled only when an operation starts
//   sample_tick           : one-cycle strobe per audio sample period
//   mem_addr/mem_we/mem_re: registered RAM port, one strobe per accepted tick
//   active_clip, mode     : latched clip and current mode (0 idle, 1 rec, 2 play)
//   clip_valid            : bit i set while clip i holds at least one sample
//   done                  : one-cycle pulse on full record or non-loop play end

// Per-clip length register. valid is derived from the length, so a clip is
// valid exactly when it holds at least one sample.
module clip_slot #(
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clr,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_len,
  output logic [CNT_W-1:0] len,
  output logic             valid
);
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)  len <= '0;
    else if (clr)  len <= '0;
    else if (wr)   len <= wr_len;
  end

  assign valid = |len;
endmodule

module clip_record_controller #(
  parameter int NUM_CLIPS  = 4,
  parameter int CLIP_DEPTH = 16384,
  parameter int CLIP_W     = $clog2(NUM_CLIPS),
  parameter int CNT_W      = $clog2(CLIP_DEPTH + 1),
  parameter int ADDR_W     = $clog2(NUM_CLIPS * CLIP_DEPTH)
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 record,
  input  logic                 play,
  input  logic                 stop,
  input  logic                 loop_en,
  input  logic [CLIP_W-1:0]    clip_sel,
  input  logic                 sample_tick,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic                 mem_we,
  output logic                 mem_re,
  output logic [CLIP_W-1:0]    active_clip,
  output logic [1:0]           mode,
  output logic [NUM_CLIPS-1:0] clip_valid,
  output logic                 done
);
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    PLAY   = 2'd2
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              we;
    logic              re;
  } mem_req_t;

  localparam logic [CNT_W-1:0] LAST_REC = CNT_W'(CLIP_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_LEN = CNT_W'(CLIP_DEPTH);

  state_t                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [CLIP_W-1:0]              clip_q, clip_d;
  mem_req_t                       req_q, req_d;
  logic                           done_q, done_d;

  logic [NUM_CLIPS-1:0]            slot_clr, slot_wr;
  logic [CNT_W-1:0]                wr_len;
  logic [NUM_CLIPS-1:0][CNT_W-1:0] len;

  logic [ADDR_W-1:0]               cur_addr;
  logic [CNT_W-1:0]                cur_len;

  genvar g;
  generate
    for (g = 0; g < NUM_CLIPS; g++) begin : g_slot
      clip_slot #(.CNT_W(CNT_W)) u_slot (
        .clock  (clock),
        .reset_n(reset_n),
        .clr    (slot_clr[g]),
        .wr     (slot_wr[g]),
        .wr_len (wr_len),
        .len    (len[g]),
        .valid  (clip_valid[g])
      );
    end
  endgenerate

  // Full-width base + offset; cnt never exceeds CLIP_DEPTH-1 when used here,
  // so the sum stays inside the clip's window.
  assign cur_addr = ADDR_W'(clip_q) * ADDR_W'(CLIP_DEPTH) + ADDR_W'(cnt_q);
  assign cur_len  = len[clip_q];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      clip_q  <= '0;
      req_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clip_q  <= clip_d;
      req_q   <= req_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    clip_d   = clip_q;
    req_d    = req_q;
    req_d.we = 1'b0;
    req_d.re = 1'b0;
    done_d   = 1'b0;
    slot_clr = '0;
    slot_wr  = '0;
    wr_len   = cnt_q;

    unique case (state_q)
      IDLE: begin
        if (stop) begin
          state_d = IDLE;
        end else if (record && !play) begin
          state_d            = RECORD;
          clip_d             = clip_sel;
          cnt_d              = '0;
          slot_clr[clip_sel] = 1'b1;
        end else if (play && !record && clip_valid[clip_sel]) begin
          state_d = PLAY;
          clip_d  = clip_sel;
          cnt_d   = '0;
        end
      end

      RECORD: begin
        if (stop) begin
          // Keep what was captured so far; zero samples leaves clip invalid.
          state_d         = IDLE;
          slot_wr[clip_q] = 1'b1;
          wr_len          = cnt_q;
        end else if (sample_tick) begin
          req_d.we   = 1'b1;
          req_d.addr = cur_addr;
          if (cnt_q == LAST_REC) begin
            state_d         = IDLE;
            slot_wr[clip_q] = 1'b1;
            wr_len          = FULL_LEN;
            done_d          = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      PLAY: begin
        if (stop) begin
          state_d = IDLE;
        end else if (sample_tick) begin
          req_d.re   = 1'b1;
          req_d.addr = cur_addr;
          if (cnt_q == cur_len - CNT_W'(1)) begin
            if (loop_en) begin
              cnt_d = '0;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign mem_addr    = req_q.addr;
  assign mem_we      = req_q.we;
  assign mem_re      = req_q.re;
  assign active_clip = clip_q;
  assign mode        = state_q;
  assign done        = done_q;
endmodule

// File: tb/tb_clip_record_controller.sv
module tb_clip_record_controller;
  localparam int NC = 4;
  localparam int CD = 8;
  localparam int CW = 2;
  localparam int AW = 5;

  logic          clock, reset_n;
  logic          record, play, stop, loop_en, sample_tick;
  logic [CW-1:0] clip_sel;
  logic [AW-1:0] mem_addr;
  logic          mem_we, mem_re, done;
  logic [CW-1:0] active_clip;
  logic [1:0]    mode;
  logic [NC-1:0] clip_valid;

  clip_record_controller #(.NUM_CLIPS(NC), .CLIP_DEPTH(CD)) dut (
    .clock(clock), .reset_n(reset_n), .record(record), .play(play),
    .stop(stop), .loop_en(loop_en), .clip_sel(clip_sel),
    .sample_tick(sample_tick), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_re(mem_re), .active_clip(active_clip), .mode(mode),
    .clip_valid(clip_valid), .done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic          we;
    logic          re;
    logic [AW-1:0] addr;
  } exp_t;

  typedef struct packed {
    logic          rec;
    logic          ply;
    logic          stp;
    logic [CW-1:0] sel;
    logic [1:0]    exp_mode;
    logic [NC-1:0] exp_valid;
  } vec_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Strobe scoreboard and done counter, sampled after each rising edge.
  always @(posedge clock) begin
    #2;
    if (done) done_cnt++;
    if (mem_we || mem_re) begin
      if (sb.size() == 0) begin
        chk("unexpected_strobe", 32'({mem_we, mem_re, mem_addr}), 32'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("strobe", 32'({mem_we, mem_re, mem_addr}), 32'(e));
      end
    end
  end

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic tick_exp(input logic we, input logic re, input logic [AW-1:0] addr);
    exp_t e;
    e = '{we: we, re: re, addr: addr};
    sb.push_back(e);
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
    cyc();
  endtask

  task automatic tick_none();
    sample_tick = 1'b1;
    cyc();
    sample_tick = 1'b0;
    cyc();
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{rec:1'b0, ply:1'b1, stp:1'b0, sel:2'd3, exp_mode:2'd0, exp_valid:4'b0110};
    vecs[1] = '{rec:1'b1, ply:1'b1, stp:1'b0, sel:2'd0, exp_mode:2'd0, exp_valid:4'b0110};
    vecs[2] = '{rec:1'b1, ply:1'b0, stp:1'b1, sel:2'd0, exp_mode:2'd0, exp_valid:4'b0110};
    vecs[3] = '{rec:1'b0, ply:1'b1, stp:1'b0, sel:2'd2, exp_mode:2'd2, exp_valid:4'b0110};
    vecs[4] = '{rec:1'b1, ply:1'b0, stp:1'b0, sel:2'd3, exp_mode:2'd1, exp_valid:4'b0110};
    vecs[5] = '{rec:1'b0, ply:1'b1, stp:1'b0, sel:2'd0, exp_mode:2'd0, exp_valid:4'b0110};

    reset_n = 1'b0; record = 1'b0; play = 1'b0; stop = 1'b0;
    loop_en = 1'b0; sample_tick = 1'b0; clip_sel = '0;

    // 1: reset with ticks toggling, then release
    for (int i = 0; i < 3; i++) tick_none();
    chk("rst_mode", 32'(mode), 32'(0));
    chk("rst_strobes", 32'({mem_we, mem_re, done}), 32'(0));
    chk("rst_valid", 32'(clip_valid), 32'(0));
    reset_n = 1'b1;
    cyc();
    for (int i = 0; i < 3; i++) tick_none();
    chk("idle_mode", 32'(mode), 32'(0));
    chk("idle_valid", 32'(clip_valid), 32'(0));

    // 2: full record of clip 2
    record = 1'b1; clip_sel = 2'd2;
    cyc();
    record = 1'b0; clip_sel = 2'd0;
    chk("rec2_mode", 32'(mode), 32'(1));
    chk("rec2_active", 32'(active_clip), 32'(2));
    for (int i = 0; i < CD; i++) tick_exp(1'b1, 1'b0, AW'(16 + i));
    chk("rec2_done", 32'(done_cnt), 32'(1));
    chk("rec2_mode_end", 32'(mode), 32'(0));
    chk("rec2_valid", 32'(clip_valid), 32'(4'b0100));

    // 3: partial record of clip 1, then non-loop play past the end
    record = 1'b1; clip_sel = 2'd1;
    cyc();
    record = 1'b0;
    for (int i = 0; i < 3; i++) tick_exp(1'b1, 1'b0, AW'(8 + i));
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("rec1_mode", 32'(mode), 32'(0));
    chk("rec1_done", 32'(done_cnt), 32'(1));
    chk("rec1_valid", 32'(clip_valid), 32'(4'b0110));
    play = 1'b1; clip_sel = 2'd1; loop_en = 1'b0;
    cyc();
    play = 1'b0;
    chk("play1_mode", 32'(mode), 32'(2));
    for (int i = 0; i < 3; i++) tick_exp(1'b0, 1'b1, AW'(8 + i));
    tick_none();
    tick_none();
    chk("play1_done", 32'(done_cnt), 32'(2));
    chk("play1_mode_end", 32'(mode), 32'(0));

    // 4: looped play of clip 1, then stop
    play = 1'b1; loop_en = 1'b1;
    cyc();
    play = 1'b0;
    for (int i = 0; i < 7; i++) tick_exp(1'b0, 1'b1, AW'(8 + (i % 3)));
    chk("loop_mode", 32'(mode), 32'(2));
    stop = 1'b1;
    cyc();
    stop = 1'b0; loop_en = 1'b0;
    chk("loop_stop_mode", 32'(mode), 32'(0));
    chk("loop_done", 32'(done_cnt), 32'(2));

    // 5: request table from IDLE, each followed by stop
    foreach (vecs[k]) begin
      record = vecs[k].rec; play = vecs[k].ply; stop = vecs[k].stp;
      clip_sel = vecs[k].sel;
      cyc();
      record = 1'b0; play = 1'b0; stop = 1'b0;
      chk($sformatf("vec%0d_mode", k), 32'(mode), 32'(vecs[k].exp_mode));
      if (vecs[k].exp_mode == 2'd0) tick_none();
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      chk($sformatf("vec%0d_idle", k), 32'(mode), 32'(0));
      chk($sformatf("vec%0d_valid", k), 32'(clip_valid), 32'(vecs[k].exp_valid));
    end
    // stop and tick together while recording: stop wins
    record = 1'b1; clip_sel = 2'd0;
    cyc();
    record = 1'b0;
    tick_exp(1'b1, 1'b0, AW'(0));
    stop = 1'b1; sample_tick = 1'b1;
    cyc();
    stop = 1'b0; sample_tick = 1'b0;
    cyc();
    chk("stoptick_mode", 32'(mode), 32'(0));
    chk("stoptick_valid", 32'(clip_valid), 32'(4'b0111));
    chk("stoptick_done", 32'(done_cnt), 32'(2));

    // 6: async reset in the middle of recording clip 0
    record = 1'b1; clip_sel = 2'd0;
    cyc();
    record = 1'b0;
    chk("rec0_valid", 32'(clip_valid), 32'(4'b0110));
    for (int i = 0; i < 4; i++) tick_exp(1'b1, 1'b0, AW'(i));
    begin
      exp_t e;
      e = '{we: 1'b1, re: 1'b0, addr: AW'(4)};
      sb.push_back(e);
    end
    sample_tick = 1'b1;
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_strobe", 32'({mem_we, mem_re, done}), 32'(0));
    chk("async_mode", 32'(mode), 32'(0));
    chk("async_valid", 32'(clip_valid), 32'(0));
    chk("async_clip_addr", 32'({active_clip, mem_addr}), 32'(0));
    sample_tick = 1'b0;
    cyc();
    reset_n = 1'b1;
    play = 1'b1; clip_sel = 2'd2;
    cyc();
    play = 1'b0;
    chk("post_rst_play", 32'(mode), 32'(0));
    tick_none();
    chk("sb_empty", 32'(sb.size()), 32'(0));
    chk("final_done", 32'(done_cnt), 32'(2));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/clip_record_controller.md
Name: clip_record_controller

Overview:
- Parametrised successor to the single-pair record/play controller.
- Manages NUM_CLIPS audio clip slots in one shared sample memory.
- Generates per-sample memory addresses and strobes for record and playback. Tracks the recorded length of each clip. Supports stop, loop playback and a completion pulse.
- Sits between the user-input debouncers/switch decoder and the sample RAM. Replaces the fixed 2-second external timer with sample counting paced by an external sample_tick.

Parameters:
- NUM_CLIPS, 4, number of clip slots (≥2).
- CLIP_DEPTH, 16384, maximum samples per clip (≥2).
- CLIP_W, $clog2(NUM_CLIPS), clip index width (derived).
- CNT_W, $clog2(CLIP_DEPTH+1), sample count/length width (derived).
- ADDR_W, $clog2(NUM_CLIPS*CLIP_DEPTH), memory address width (derived).

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- record  in  1  level request to record into clip_sel
- play  in  1  level request to play clip_sel
- stop  in  1  level request to abort current operation
- loop_en  in  1  1 = playback wraps to sample 0 at end of clip
- clip_sel  in  CLIP_W  requested clip slot, sampled only on operation start
- sample_tick  in  1  one-cycle strobe per audio sample period
- mem_addr  out  ADDR_W  sample RAM address
- mem_we  out  1  write strobe, one cycle per recorded sample
- mem_re  out  1  read strobe, one cycle per played sample
- active_clip  out  CLIP_W  clip latched at operation start
- mode  out  2  0 = IDLE, 1 = RECORD, 2 = PLAY
- clip_valid  out  NUM_CLIPS  bit i set when clip i holds ≥1 sample
- done  out  1  one-cycle pulse on natural end of record or non-loop play

Behaviour:

Reset:
- reset_n low forces the following immediately, independent of clock: mode = IDLE; mem_addr, mem_we, mem_re, active_clip and done = 0; clip_valid = 0; all clip lengths = 0; sample counter = 0.
- Reset mid-operation discards the clip in progress.

State machine (registered):
- IDLE:
  - stop high → stay IDLE.
  - Else record & ~play → RECORD.
  - Else play & ~record and clip_valid[clip_sel] → PLAY.
  - record & play both high → stay IDLE (ignored).
  - play on an invalid clip → ignored.
- Entering RECORD or PLAY latches clip_sel into active_clip and clears the sample counter cnt.
- Entering RECORD also clears clip_valid[clip_sel] and len[clip_sel].
- clip_sel changes during an operation are ignored.

Address and strobe timing:
- mem_addr = active_clip*CLIP_DEPTH + cnt, computed at ADDR_W width with no overflow.
- Registered with mem_we/mem_re, so latency is one cycle after the sample_tick cycle.
- Strobes are high exactly one cycle per accepted tick.
- Ticks while in IDLE produce no strobe.

RECORD:
- Each sample_tick: mem_we = 1 at the address above, then cnt++.
- On the tick where cnt == CLIP_DEPTH-1:
  - len[active_clip] = CLIP_DEPTH
  - clip_valid bit set
  - done pulses the following cycle
  - mode → IDLE
- stop asserted (checked before tick):
  - len[active_clip] = cnt
  - clip_valid bit = (cnt != 0)
  - → IDLE, no done
- stop and sample_tick in the same cycle: stop wins, no strobe.
- record deasserted mid-record has no effect; only stop or full ends recording.

PLAY:
- Each sample_tick: mem_re = 1 at the address above.
- If cnt == len[active_clip]-1:
  - loop_en = 1 → cnt = 0, stay in PLAY, no done.
  - loop_en = 0 → done pulse the following cycle, → IDLE.
- Otherwise cnt++.
- loop_en is sampled at each end-of-clip tick.
- stop → IDLE without done; same-cycle stop beats tick.
- Record requests are ignored during PLAY.

Other rules:
- done is never asserted in the same cycle as a strobe of a new operation.
- A new operation may start on the cycle after return to IDLE.
- Lengths are held in NUM_CLIPS registers of CNT_W bits.

Test Plan (NUM_CLIPS=4, CLIP_DEPTH=8):
1. Reset held, then released with ticks toggling → mode = 0, mem_we = mem_re = 0, clip_valid = 4'b0000; no strobes.
2. record with clip_sel=2, then 8 ticks → mem_we on addresses 16..23, one cycle after each tick. done pulses once, mode returns to 0, clip_valid = 4'b0100.
3. record with clip_sel=1, 3 ticks, then stop → addresses 8..10 written, no done, clip_valid = 4'b0110. Then play clip 1 with 5 ticks and loop_en=0 → mem_re on 8, 9, 10, done pulse, and the remaining 2 ticks produce no strobes.
4. play clip 1 with loop_en=1 and 7 ticks → read addresses 8, 9, 10, 8, 9, 10, 8 with no done. Then stop → mode 0, no done.
5. play clip 3 (invalid), and record+play simultaneously → mode stays 0, no strobes. stop in the same cycle as a tick during RECORD → no mem_we for that tick.
6. reset_n pulled low asynchronously mid-record of clip 0 after 4 ticks → outputs clear without a clock edge, clip_valid = 0. After release, play clip 2 is ignored.
